cpu_pipe_br: RTL
================

Name: cpu_pipe_br

Overview:
- Parametrised successor to the team's 3-stage RV32 core (Fetch, EX, WB), with GPIO mapped through CSRs.
- Adds conditional branches, JAL and JALR with a one-bubble flush, WB→EX forwarding and NUM_GPIO independent GPIO channels.
- Instruction memory sits outside this block and has synchronous read: data appears one cycle after the address is presented.
- Sits at top level between the instruction ROM and the board I/O.

Parameters:
- IMEM_AW, 12, instruction word-address width.
- NUM_GPIO, 2, number of 32-bit GPIO in/out channel pairs (1..8).
- RESET_PC, 0, word address fetched after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  IMEM_AW  word address to instruction memory.
- imem_rdata  in  32  instruction, valid the cycle after imem_addr.
- gpio_in  in  32*NUM_GPIO  channel c occupies bits [32c+31:32c].
- gpio_out  out  32*NUM_GPIO  registered output channels.
- pc_ex  out  IMEM_AW  word address of the instruction now in EX (debug).
- ex_valid  out  1  EX holds a valid, unflushed instruction.
- wb_we  out  1  register-file write enable in WB.
- wb_addr  out  5  WB destination register.
- wb_data  out  32  WB write data.

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- Values while rst_n=0:
  - pc_fetch=RESET_PC; ex_valid=0; wb_we=0; wb_addr=0; wb_data=0; gpio_out all 0.
  - Register file contents are unspecified, except x0, which always reads 0.
- First cycle after release: imem_addr=RESET_PC, ex_valid=0.
- Second cycle: EX holds the instruction at RESET_PC, ex_valid=1.
- Fetch:
  - imem_addr=pc_fetch.
  - pc_fetch advances by 1 each cycle unless redirected.
  - pc_fetch wraps modulo 2^IMEM_AW.
  - pc_ex is pc_fetch registered.
- Supported ISA:
  - R-type ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, MULH, MULHU.
  - I-type ALU ops, sign-extended imm12.
  - LUI.
  - CSRRW.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - JAL, JALR.
- Unsupported opcodes execute as NOPs: no register or GPIO write.
- Branch/jump target units:
  - Byte offsets are converted to word addresses by >>2.
  - Branch/JAL target = pc_ex + (imm>>>2).
  - JALR target = (rs1 + imm)[IMEM_AW+1:2].
  - JAL/JALR link value = (pc_ex+1)<<2.
- Branch resolution and flush:
  - Resolved combinationally in EX.
  - If taken and ex_valid=1, pc_fetch <= target next edge.
  - The instruction arriving the next cycle is squashed: ex_valid=0, no writes.
  - Taken branch cost is exactly 1 bubble; not-taken cost is 0.
  - A squashed instruction cannot redirect, even if it is itself a branch.
- GPIO via CSRRW:
  - csr = 0xF00 + 2c reads gpio_in[c]; csr = 0xF02 + 2c writes gpio_out[c].
  - The CSR is decoded from imm12.
  - A write captures rs1 at the end of EX.
  - rd receives the channel's input value, registered in WB.
  - c >= NUM_GPIO: reads return 0, writes are ignored.
- Writeback:
  - EX results register into WB; the register file is written at the end of WB.
  - Writes to x0 are suppressed: wb_we=0.
- Forwarding:
  - If WB writes rsN≠0 in the same cycle EX reads rsN, EX uses wb_data.
  - No stalls exist anywhere in the pipeline.
- Simultaneous events:
  - A branch in EX whose rs1 is forwarded from WB uses the forwarded value.
  - A GPIO write and a branch in the same instruction cannot occur: they are different opcodes.
- Reset mid-operation: all state returns to reset values immediately; any in-flight WB write is lost.

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants: OP_R, OP_I, OP_LUI, OP_BR, OP_JAL, OP_JALR, OP_CSR.
  - CSR_GPIO_IN_BASE=0xF00 and CSR_GPIO_OUT_BASE=0xF02.
  - An aluop_t enum.
  - A typedef struct ctrl_t bundling regwrite, regsel, alusrc, aluop, is_branch, is_jal, is_jalr and gpio_we.
- Reuse the existing alu, regfile and instruction decoder.
- New sub-module branch_unit: inputs funct3, rs1, rs2; output taken.

Test Plan:
1. Reset sequencing: addi x1,x0,5 ; addi x2,x1,3 back-to-back → wb_data 5, then 8 via forwarding; wb_addr 1, then 2.
2. Taken branch: beq x0,x0,+8 at pc 4 → next valid pc_ex=6; the instruction at pc 5 shows ex_valid=0 and wb_we never asserts for it.
3. Not-taken branch: bne x0,x0,+8 → pc_ex sequence 4,5,6 with no bubble.
4. JAL/JALR: jal x1,+12 at pc 2 → x1=12, pc_ex=5. Then jalr x0,0(x1) → pc_ex=3, one bubble.
5. GPIO channels, NUM_GPIO=2: gpio_in[1]=0xDEADBEEF; csrrw x3,0xF02(+2=0xF04)... Expected results:
   - csrrw x3,0xF02,x0 reads channel 1 → x3=0xDEADBEEF.
   - csrrw x0,0xF04,x3 → gpio_out[1]=0xDEADBEEF one edge after EX; gpio_out[0] unchanged.
   - Access to channel 2 reads 0 and writes nothing.
6. Reset mid-stream: assert rst_n=0 asynchronously mid-cycle while a branch is in EX → gpio_out=0, wb_we=0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the cpu_pipe_br core: opcode constants, the GPIO CSR
// map, the ALU operation encoding, the control bundle produced by the decoder,
// and the decoder and ALU themselves as functions.
// No ports (package).
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_CSR  = 7'b1110011;

    localparam logic [11:0] CSR_GPIO_IN_BASE  = 12'hF00;
    localparam logic [11:0] CSR_GPIO_OUT_BASE = 12'hF02;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
        ALU_MUL, ALU_MULH, ALU_MULHU, ALU_PASSB
    } aluop_t;

    typedef enum logic [1:0] {SEL_ALU, SEL_LINK, SEL_GPIO} regsel_t;

    typedef struct packed {
        logic    regwrite;
        regsel_t regsel;
        logic    alusrc;
        aluop_t  aluop;
        logic    is_branch;
        logic    is_jal;
        logic    is_jalr;
        logic    gpio_we;
    } ctrl_t;

    // Anything not recognised leaves regwrite/gpio_we low, so it runs as a NOP.
    function automatic ctrl_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                     input logic [6:0] funct7);
        ctrl_t c;
        c = '{regwrite: 1'b0, regsel: SEL_ALU, alusrc: 1'b0, aluop: ALU_ADD,
              is_branch: 1'b0, is_jal: 1'b0, is_jalr: 1'b0, gpio_we: 1'b0};
        case (opcode)
            OP_R: begin
                c.regwrite = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: c.aluop = ALU_ADD;
                    {7'b0100000, 3'b000}: c.aluop = ALU_SUB;
                    {7'b0000000, 3'b001}: c.aluop = ALU_SLL;
                    {7'b0000000, 3'b010}: c.aluop = ALU_SLT;
                    {7'b0000000, 3'b011}: c.aluop = ALU_SLTU;
                    {7'b0000000, 3'b100}: c.aluop = ALU_XOR;
                    {7'b0000000, 3'b101}: c.aluop = ALU_SRL;
                    {7'b0100000, 3'b101}: c.aluop = ALU_SRA;
                    {7'b0000000, 3'b110}: c.aluop = ALU_OR;
                    {7'b0000000, 3'b111}: c.aluop = ALU_AND;
                    {7'b0000001, 3'b000}: c.aluop = ALU_MUL;
                    {7'b0000001, 3'b001}: c.aluop = ALU_MULH;
                    {7'b0000001, 3'b011}: c.aluop = ALU_MULHU;
                    default:              c.regwrite = 1'b0;
                endcase
            end
            OP_I: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                case (funct3)
                    3'b000:  c.aluop = ALU_ADD;
                    3'b010:  c.aluop = ALU_SLT;
                    3'b011:  c.aluop = ALU_SLTU;
                    3'b100:  c.aluop = ALU_XOR;
                    3'b110:  c.aluop = ALU_OR;
                    3'b001: begin
                        c.aluop    = ALU_SLL;
                        c.regwrite = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        c.aluop    = funct7[5] ? ALU_SRA : ALU_SRL;
                        c.regwrite = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: c.aluop = ALU_AND;
                endcase
            end
            OP_LUI: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALU_PASSB;
            end
            OP_BR:  c.is_branch = 1'b1;
            OP_JAL: begin
                c.regwrite = 1'b1;
                c.regsel   = SEL_LINK;
                c.is_jal   = 1'b1;
            end
            OP_JALR: begin
                c.regwrite = (funct3 == 3'b000);
                c.regsel   = SEL_LINK;
                c.is_jalr  = (funct3 == 3'b000);
            end
            OP_CSR: begin
                c.regwrite = (funct3 == 3'b001);
                c.regsel   = SEL_GPIO;
                c.gpio_we  = (funct3 == 3'b001);
            end
            default: ;
        endcase
        return c;
    endfunction

    // One signed 33x33-style product serves all three multiplies; the unsigned
    // high word is the signed high word corrected for negative operands.
    function automatic logic [31:0] alu(input aluop_t op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic [63:0] ps;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
            ALU_SLT:   return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  return {31'b0, a < b};
            ALU_MUL:   return ps[31:0];
            ALU_MULH:  return ps[63:32];
            ALU_MULHU: return ps[63:32] + (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
            default:   return b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_pipe_br_branch_unit.sv
// branch_unit
// Evaluates the conditional-branch comparison for the instruction in EX.
// Ports: funct3 (branch kind), rs1/rs2 (operands, already forwarded),
//        taken (condition holds; unknown funct3 codes never take).
module branch_unit (
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (rs1 == rs2);
            3'b001:  taken = (rs1 != rs2);
            3'b100:  taken = ($signed(rs1) <  $signed(rs2));
            3'b101:  taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  taken = (rs1 <  rs2);
            3'b111:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_pipe_br.sv
// cpu_pipe_br
// Three-stage RV32 subset core (Fetch, EX, WB) with branches/jumps resolved in
// EX at a one-bubble cost, WB->EX forwarding and NUM_GPIO CSR-mapped GPIO pairs.
// Ports: clk, rst_n (async active-low); imem_addr/imem_rdata (synchronous-read
// instruction memory); gpio_in/gpio_out (32 bits per channel); pc_ex, ex_valid
// (debug view of EX); wb_we/wb_addr/wb_data (register-file write in WB).
module cpu_pipe_br
    import cpu_pkg::*;
#(
    parameter int IMEM_AW  = 12,
    parameter int NUM_GPIO = 2,
    parameter int RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic [32*NUM_GPIO-1:0] gpio_in,
    output logic [32*NUM_GPIO-1:0] gpio_out,
    output logic [IMEM_AW-1:0]     pc_ex,
    output logic                   ex_valid,
    output logic                   wb_we,
    output logic [4:0]             wb_addr,
    output logic [31:0]            wb_data
);
    localparam logic [IMEM_AW-1:0] PC0 = IMEM_AW'(RESET_PC);

    logic [IMEM_AW-1:0] pc_fetch, br_target, jalr_target, target;
    logic [31:0]        instr, imm_i, imm_u, imm_b, imm_j, br_off, br_off_w;
    logic [31:0]        rs1_val, rs2_val, op_b, alu_y, link_val, gpio_rdata, result, jalr_sum;
    logic [4:0]         rs1_addr, rs2_addr, rd_addr;
    logic [11:0]        in_off, out_off;
    logic               br_cond, redirect;
    ctrl_t              ctrl;
    logic [31:0]        regs [32];
    logic               unused_bits;

    // EX consumes the memory output directly: it belongs to last cycle's pc_fetch.
    assign imem_addr = pc_fetch;
    assign instr     = imem_rdata;
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];
    assign rd_addr   = instr[11:7];
    assign ctrl      = decode(instr[6:0], instr[14:12], instr[31:25]);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 reads as zero; WB's result wins over the not-yet-written register file.
    assign rs1_val = (wb_we && wb_addr == rs1_addr) ? wb_data :
                     (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_val = (wb_we && wb_addr == rs2_addr) ? wb_data :
                     (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

    assign op_b  = ctrl.alusrc ? ((instr[6:0] == OP_LUI) ? imm_u : imm_i) : rs2_val;
    assign alu_y = alu(ctrl.aluop, rs1_val, op_b);

    branch_unit u_branch (
        .funct3 (instr[14:12]),
        .rs1    (rs1_val),
        .rs2    (rs2_val),
        .taken  (br_cond)
    );

    // Byte offsets become word offsets with an arithmetic shift so backward
    // targets keep their sign before truncation to the fetch width.
    assign br_off      = ctrl.is_jal ? imm_j : imm_b;
    assign br_off_w    = 32'($signed(br_off) >>> 2);
    assign br_target   = pc_ex + br_off_w[IMEM_AW-1:0];
    assign jalr_sum    = rs1_val + imm_i;
    assign jalr_target = jalr_sum[IMEM_AW+1:2];
    assign target      = ctrl.is_jalr ? jalr_target : br_target;
    assign redirect    = ex_valid && ((ctrl.is_branch && br_cond) || ctrl.is_jal || ctrl.is_jalr);
    assign link_val    = 32'({pc_ex + IMEM_AW'(1), 2'b00});

    // One CSRRW both reads input channel (csr-0xF00)/2 and writes output
    // channel (csr-0xF02)/2; odd offsets and missing channels match nothing.
    assign in_off  = instr[31:20] - CSR_GPIO_IN_BASE;
    assign out_off = instr[31:20] - CSR_GPIO_OUT_BASE;

    always_comb begin
        gpio_rdata = 32'd0;
        for (int c = 0; c < NUM_GPIO; c++) begin
            if (!in_off[0] && in_off[11:1] == 11'(c)) begin
                gpio_rdata = gpio_in[32*c +: 32];
            end
        end
    end

    always_comb begin
        result = alu_y;
        case (ctrl.regsel)
            SEL_LINK: result = link_val;
            SEL_GPIO: result = gpio_rdata;
            default:  result = alu_y;
        endcase
    end

    // Fetch/EX/WB pipeline registers and GPIO outputs. A redirect squashes
    // the instruction already requested from memory by clearing ex_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_fetch <= PC0;
            pc_ex    <= PC0;
            ex_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            gpio_out <= '0;
        end else begin
            pc_fetch <= redirect ? target : pc_fetch + IMEM_AW'(1);
            pc_ex    <= pc_fetch;
            ex_valid <= !redirect;
            wb_we    <= ex_valid && ctrl.regwrite && (rd_addr != 5'd0);
            wb_addr  <= rd_addr;
            wb_data  <= result;
            for (int c = 0; c < NUM_GPIO; c++) begin
                if (ex_valid && ctrl.gpio_we && !out_off[0] && out_off[11:1] == 11'(c)) begin
                    gpio_out[32*c +: 32] <= rs1_val;
                end
            end
        end
    end

    // Register file storage has no reset; x0 is never written because wb_we
    // is already suppressed for rd == 0.
    always_ff @(posedge clk) begin
        if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign unused_bits = ^{jalr_sum, br_off_w};

endmodule
